// File: rtl/uart_receive.sv
// 8N1 UART receiver: synchronises rx, times bits from a mid-start-bit anchor and
// presents each good byte on Pixel with a one-cycle recvFlag (frameErr on a bad stop bit).
module uart_receive #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] Pixel,
  output logic       recvFlag,
  output logic       frameErr,
  output logic       busy
);

  localparam int CPB   = CLK_FREQ / BAUD;
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;

  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CPB - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       pixel_q, pixel_d;
  logic             flag_q, flag_d;
  logic             err_q, err_d;
  logic [1:0]       sync_q;
  logic             rxs;

  // NOTE: the synchroniser resets to 1 (line idle) so leaving reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  assign rxs = sync_q[1];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      pixel_q <= '0;
      flag_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      pixel_q <= pixel_d;
      flag_q  <= flag_d;
      err_q   <= err_d;
    end
  end

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pixel_d = pixel_q;
    flag_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (cnt_q == CNT_HALF_LAST) begin
          cnt_d = '0;
          bit_d = '0;
          // A start bit that is already gone at mid-bit was a glitch.
          state_d = rxs ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt_q == CNT_BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt_q == CNT_BIT_LAST) begin
          // Leave mid stop bit so a directly following start edge is not missed.
          cnt_d   = '0;
          state_d = IDLE;
          if (rxs) begin
            pixel_d = shift_q;
            flag_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign Pixel    = pixel_q;
  assign recvFlag = flag_q;
  assign frameErr = err_q;
  assign busy     = (state_q != IDLE);

endmodule
